// File: rtl/avalon_io_responder.sv
// Avalon-MM IO responder: splits each word-aligned 32-bit command into
// byte-wide device-bus cycles, lowest enabled lane first, and returns the
// assembled read word with a single readdatavalid pulse.
module avalon_io_responder #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] avs_address,
  input  logic [3:0]  avs_byteenable,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_waitrequest,
  output logic [15:0] dev_address,
  output logic        dev_read,
  output logic        dev_write,
  output logic [7:0]  dev_writedata,
  input  logic [7:0]  dev_readdata,
  input  logic        dev_ready,
  output logic        dev_timeout
);

  localparam int          NUM_LANES = 4;
  localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, GAP, DONE} state_t;

  // Command captured at acceptance; mask shrinks as lanes complete.
  typedef struct packed {
    logic [13:0]          base;
    logic [NUM_LANES-1:0] mask;
    logic [31:0]          wdata;
    logic                 is_write;
  } cmd_t;

  state_t               state, state_nxt;
  cmd_t                 cmd;
  logic [31:0]          rbuf, rbuf_nxt;
  logic [15:0]          cnt;
  logic [1:0]           lane;
  logic [NUM_LANES-1:0] lane_bit;
  logic                 accept, byte_done, byte_to, more;

  // Word address bits [1:0] carry no information for a word-aligned port.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^avs_address[1:0];

  // Pick the lowest lane still pending; later lanes are serviced in turn.
  always_comb begin
    lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (cmd.mask[i]) lane = 2'(i);
  end

  assign lane_bit  = NUM_LANES'(1) << lane;
  assign accept    = (state == IDLE) && (avs_read || avs_write);
  assign byte_done = (state == ACCESS) && (dev_ready || cnt == CNT_LAST);
  assign byte_to   = (state == ACCESS) && !dev_ready && (cnt == CNT_LAST);
  assign more      = |(cmd.mask & ~lane_bit);

  // Read buffer with the completing byte merged in; a timed-out lane stays 8'hFF.
  always_comb begin
    rbuf_nxt = rbuf;
    if (byte_done && dev_ready && !cmd.is_write)
      rbuf_nxt[{lane, 3'b000} +: 8] = dev_readdata;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (avs_byteenable == '0) ? DONE : ACCESS;
      ACCESS:  if (byte_done) state_nxt = more ? GAP : DONE;
      GAP:     state_nxt = ACCESS;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Device-bus and waitrequest outputs, decoded from state so reset drops them at once.
  always_comb begin
    avs_waitrequest = (state != IDLE);
    dev_read        = 1'b0;
    dev_write       = 1'b0;
    dev_address     = '0;
    dev_writedata   = '0;
    if (state == ACCESS) begin
      dev_read      = !cmd.is_write;
      dev_write     = cmd.is_write;
      dev_address   = {cmd.base, lane};
      dev_writedata = cmd.wdata[{lane, 3'b000} +: 8];
    end
  end

  // Command capture, lane bookkeeping, wait counter and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd               <= '0;
      rbuf              <= '0;
      cnt               <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
      dev_timeout       <= 1'b0;
    end else begin
      avs_readdatavalid <= 1'b0;
      dev_timeout       <= byte_to;
      if (accept) begin
        // A simultaneous read+write is treated as a write.
        cmd.base     <= avs_address[15:2];
        cmd.mask     <= avs_byteenable;
        cmd.wdata    <= avs_writedata;
        cmd.is_write <= avs_write;
        rbuf         <= '1;
        cnt          <= '0;
        if (avs_byteenable == '0 && !avs_write) begin
          avs_readdatavalid <= 1'b1;
          avs_readdata      <= '1;
        end
      end else if (state == ACCESS) begin
        if (byte_done) begin
          cnt      <= '0;
          cmd.mask <= cmd.mask & ~lane_bit;
          rbuf     <= rbuf_nxt;
          if (!more && !cmd.is_write) begin
            avs_readdatavalid <= 1'b1;
            avs_readdata      <= rbuf_nxt;
          end
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

endmodule
